// File: rtl/sample_mac_accum.sv
// ---------------------------------------------------------------------------
// sample_mac_accum
// Accumulates N_TERMS signed products per output neuron, seeds the sum with a
// per-neuron bias, optionally applies ReLU and saturates the result to OUT_W.
// One result per neuron is presented on a valid/ready interface.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   bias       : signed bias, sampled with the first product of each neuron
//   prod_valid : product valid
//   prod_ready : block accepts a product this cycle (registered)
//   prod_data  : signed product from the multiplier
//   out_valid  : result valid (registered)
//   out_ready  : consumer accepts the result
//   out_data   : signed saturated (optionally ReLU'd) result (registered)
//   out_sat    : result was clipped by saturation (registered)
// ---------------------------------------------------------------------------
module sample_mac_accum #(
  parameter int PROD_W  = 14,
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 14,
  parameter int N_TERMS = 16,
  parameter int CNT_W   = 5,
  parameter int RELU    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OUT_W-1:0] bias,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  localparam int HI_INT = (2 ** (OUT_W - 1)) - 1;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(HI_INT);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-HI_INT - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             prod_ready_nxt;
  logic             out_valid_nxt;
  logic [OUT_W-1:0] out_data_nxt;
  logic             out_sat_nxt;
  logic             accept;
  logic [ACC_W-1:0] sum;
  logic [OUT_W:0]   sat_res;

  // Returns {sat_flag, data}: ReLU first, then clip to the OUT_W signed range.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] s);
    logic [OUT_W:0] r;
    if ((RELU != 0) && s[ACC_W-1]) begin
      r = {1'b0, {OUT_W{1'b0}}};
    end else if (s > SAT_HI) begin
      r = {1'b1, SAT_HI[OUT_W-1:0]};
    end else if (s < SAT_LO) begin
      r = {1'b1, SAT_LO[OUT_W-1:0]};
    end else begin
      r = {1'b0, s[OUT_W-1:0]};
    end
    return r;
  endfunction

  // Datapath: the first term of a neuron replaces the old sum with the bias.
  always_comb begin
    accept = prod_valid & prod_ready;
    if (cnt == {CNT_W{1'b0}}) begin
      sum = {{(ACC_W-OUT_W){bias[OUT_W-1]}}, bias}
          + {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
    end else begin
      sum = acc + {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
    end
    sat_res = saturate(sum);
  end

  // Next-state and next-output logic for the ACC/HOLD controller.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    acc_nxt        = acc;
    prod_ready_nxt = prod_ready;
    out_valid_nxt  = out_valid;
    out_data_nxt   = out_data;
    out_sat_nxt    = out_sat;
    case (state)
      ACC: begin
        prod_ready_nxt = 1'b1;
        if (accept) begin
          acc_nxt = sum;
          if (cnt == LAST_CNT) begin
            cnt_nxt        = {CNT_W{1'b0}};
            out_valid_nxt  = 1'b1;
            out_data_nxt   = sat_res[OUT_W-1:0];
            out_sat_nxt    = sat_res[OUT_W];
            prod_ready_nxt = 1'b0;
            state_nxt      = HOLD;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else begin
          acc_nxt = acc;
        end
      end
      HOLD: begin
        prod_ready_nxt = 1'b0;
        // Ready is not re-asserted in the handshake cycle: one bubble between neurons.
        if (out_ready) begin
          out_valid_nxt  = 1'b0;
          prod_ready_nxt = 1'b1;
          state_nxt      = ACC;
        end else begin
          out_valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt      = ACC;
        cnt_nxt        = {CNT_W{1'b0}};
        acc_nxt        = {ACC_W{1'b0}};
        prod_ready_nxt = 1'b0;
        out_valid_nxt  = 1'b0;
      end
    endcase
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ACC;
      cnt        <= {CNT_W{1'b0}};
      acc        <= {ACC_W{1'b0}};
      prod_ready <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= {OUT_W{1'b0}};
      out_sat    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      acc        <= acc_nxt;
      prod_ready <= prod_ready_nxt;
      out_valid  <= out_valid_nxt;
      out_data   <= out_data_nxt;
      out_sat    <= out_sat_nxt;
    end
  end

endmodule

// File: tb/tb_sample_mac_accum.sv
// ---------------------------------------------------------------------------
// tb_sample_mac_accum
// Directed bench: two 4-term instances (RELU=0 and RELU=1) share stimulus,
// a third 1-term instance has its own stimulus. Expected results are
// hand-computed in a vector table; reset and single-term corner cases are
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_sample_mac_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [13:0] bias, pd, c_bias, c_pd;
  logic pv, ordy, c_pv, c_ordy;
  logic pr_a, ov_a, os_a, pr_b, ov_b, os_b, pr_c, ov_c, os_c;
  logic [13:0] od_a, od_b, od_c;

  int checks = 0;
  int failures = 0;

  sample_mac_accum #(.N_TERMS(4), .CNT_W(3), .RELU(0)) dut_a (
    .clk(clk), .reset(reset), .bias(bias), .prod_valid(pv), .prod_ready(pr_a),
    .prod_data(pd), .out_valid(ov_a), .out_ready(ordy), .out_data(od_a), .out_sat(os_a));

  sample_mac_accum #(.N_TERMS(4), .CNT_W(3), .RELU(1)) dut_b (
    .clk(clk), .reset(reset), .bias(bias), .prod_valid(pv), .prod_ready(pr_b),
    .prod_data(pd), .out_valid(ov_b), .out_ready(ordy), .out_data(od_b), .out_sat(os_b));

  sample_mac_accum #(.N_TERMS(1), .CNT_W(1), .RELU(0)) dut_c (
    .clk(clk), .reset(reset), .bias(c_bias), .prod_valid(c_pv), .prod_ready(pr_c),
    .prod_data(c_pd), .out_valid(ov_c), .out_ready(c_ordy), .out_data(od_c), .out_sat(os_c));

  typedef struct {
    int bias; int p0; int p1; int p2; int p3;
    int hold; int gaps;
    int ea; int sa; int eb; int sb;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Present one product to dut_a/dut_b, optionally after random idle cycles.
  task automatic accept_one(input int p, input int gaps_max);
    bit ok;
    logic r;
    pv = 1'b0;
    repeat ($urandom_range(gaps_max, 0)) step();
    pd = 14'(p);
    pv = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      r = pr_a;
      step();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    pv = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic run_neuron(input vec_t v, input int idx);
    bias = 14'(v.bias);
    accept_one(v.p0, v.gaps);
    bias = 14'(1234);  // must be ignored after the first term
    accept_one(v.p1, v.gaps);
    accept_one(v.p2, v.gaps);
    accept_one(v.p3, v.gaps);
    chk($sformatf("v%0d_valid_a", idx), {31'd0, ov_a}, 1);
    chk($sformatf("v%0d_valid_b", idx), {31'd0, ov_b}, 1);
    chk($sformatf("v%0d_pready_low", idx), {31'd0, pr_a}, 0);
    chk($sformatf("v%0d_data_a", idx), $signed(od_a), v.ea);
    chk($sformatf("v%0d_sat_a", idx), {31'd0, os_a}, v.sa);
    chk($sformatf("v%0d_data_b", idx), $signed(od_b), v.eb);
    chk($sformatf("v%0d_sat_b", idx), {31'd0, os_b}, v.sb);
    if (v.hold > 0) begin
      ordy = 1'b0;
      pd = 14'(-777);
      pv = 1'b1;  // offered product must not be taken while holding
      for (int h = 0; h < v.hold; h++) begin
        step();
        chk($sformatf("v%0d_hold_valid", idx), {31'd0, ov_a}, 1);
        chk($sformatf("v%0d_hold_data", idx), $signed(od_a), v.ea);
        chk($sformatf("v%0d_hold_pready", idx), {31'd0, pr_a}, 0);
      end
      pv = 1'b0;
      ordy = 1'b1;
    end
    step();  // result handshake
    chk($sformatf("v%0d_post_valid", idx), {31'd0, ov_a}, 0);
    chk($sformatf("v%0d_post_pready", idx), {31'd0, pr_a}, 1);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    chk({tag, "_rst_pready"}, {31'd0, pr_a}, 0);
    chk({tag, "_rst_valid"}, {31'd0, ov_a}, 0);
    chk({tag, "_rst_data"}, $signed(od_a), 0);
    chk({tag, "_rst_sat"}, {31'd0, os_a}, 0);
    chk({tag, "_rst_valid_c"}, {31'd0, ov_c}, 0);
    step();
    reset = 1'b1;
    chk({tag, "_rel_pready"}, {31'd0, pr_a}, 0);
    step();
    chk({tag, "_rise_pready"}, {31'd0, pr_a}, 1);
  endtask

  task automatic c_one(input int b, input int p, input int ed, input int es, input int idx);
    bit ok;
    logic r;
    c_bias = 14'(b);
    c_pd = 14'(p);
    c_pv = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      r = pr_c;
      step();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    c_pv = 1'b0;
    if (!ok) chk("c_accept_timeout", 0, 1);
    chk($sformatf("c%0d_valid", idx), {31'd0, ov_c}, 1);
    chk($sformatf("c%0d_data", idx), $signed(od_c), ed);
    chk($sformatf("c%0d_sat", idx), {31'd0, os_c}, es);
    step();
    chk($sformatf("c%0d_post_valid", idx), {31'd0, ov_c}, 0);
    chk($sformatf("c%0d_post_pready", idx), {31'd0, pr_c}, 1);
  endtask

  initial begin
    //            bias    p0     p1     p2     p3  hold gaps  ea  sa   eb  sb
    vecs[0] = '{10, 1, 2, 3, 4, 0, 0, 20, 0, 20, 0};
    vecs[1] = '{0, 8191, 8191, 8191, 8191, 0, 0, 8191, 1, 8191, 1};
    vecs[2] = '{-8192, -8192, -8192, -8192, -8192, 5, 0, -8192, 1, 0, 0};
    vecs[3] = '{-5, 1, 1, 1, 1, 0, 0, -1, 0, 0, 0};
    vecs[4] = '{100, -50, 30, -7, 2, 2, 0, 75, 0, 75, 0};
    vecs[5] = '{8191, 0, 0, 0, 0, 0, 0, 8191, 0, 8191, 0};
    vecs[6] = '{-8192, 0, 0, 0, 0, 0, 0, -8192, 0, 0, 0};
    vecs[7] = '{8191, 1, 0, 0, 0, 0, 2, 8191, 1, 8191, 1};
    vecs[8] = '{-8192, -1, 0, 0, 0, 1, 2, -8192, 1, 0, 0};
    vecs[9] = '{-300, 200, -100, 50, 400, 0, 2, 250, 0, 250, 0};

    pv = 1'b0; ordy = 1'b1; bias = '0; pd = '0;
    c_pv = 1'b0; c_ordy = 1'b1; c_bias = '0; c_pd = '0;
    reset = 1'b1;
    #2;
    do_reset("init");

    for (int i = 0; i < 10; i++) run_neuron(vecs[i], i);

    // Reset after two of four products: partial sum must be discarded.
    bias = 14'(50);
    accept_one(100, 0);
    accept_one(200, 0);
    do_reset("mid");
    run_neuron('{7, 1, 2, 3, 4, 0, 0, 17, 0, 17, 0}, 10);

    // Reset while a result is pending.
    bias = 14'(0);
    accept_one(5, 0);
    accept_one(5, 0);
    accept_one(5, 0);
    accept_one(5, 0);
    chk("hold_pending_valid", {31'd0, ov_a}, 1);
    do_reset("hold");
    run_neuron('{-20, 3, 3, 3, 3, 0, 0, -8, 0, 0, 0}, 11);

    // Single-term instance: every product yields bias+prod immediately.
    c_one(3, 4, 7, 0, 0);
    c_one(-8192, -1, -8192, 1, 1);
    c_one(8000, 191, 8191, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
